// File: rtl/easyaxi_ar_arb_pkg.sv
// Shared EasyAXI width macros and arbiter types.
// Latency: n/a (definitions only).
// Backpressure: n/a.
`ifndef EASYAXI_DEFINE_SVH
`define EASYAXI_DEFINE_SVH
`define AXI_ID_W        4
`define AXI_ADDR_W      32
`define AXI_LEN_W       8
`define AXI_SIZE_W      3
`define AXI_BURST_W     2
`define AXI_DATA_W      32
`define AXI_RESP_W      2
`define AXI_MST_NUM     2
`define AXI_SID_W       (`AXI_ID_W+1)
`define AXI_SIZE_1B     3'b000
`define AXI_SIZE_2B     3'b001
`define AXI_SIZE_4B     3'b010
`define AXI_SIZE_8B     3'b011
`define AXI_BURST_FIXED 2'b00
`define AXI_BURST_INCR  2'b01
`define AXI_BURST_WRAP  2'b10
`endif

package easyaxi_ar_arb_pkg;

    localparam int MST_NUM = `AXI_MST_NUM;
    localparam int SID_W   = `AXI_SID_W;

    // AR payload carried from a master to the slave port.
    typedef struct packed {
        logic [`AXI_ID_W-1:0]    id;
        logic [`AXI_ADDR_W-1:0]  addr;
        logic [`AXI_LEN_W-1:0]   len;
        logic [`AXI_SIZE_W-1:0]  size;
        logic [`AXI_BURST_W-1:0] burst;
    } ar_pl_t;

    // Master index to one-hot grant vector.
    function automatic logic [MST_NUM-1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/easyaxi_rr_arb.sv
// 2-way round-robin arbiter; the grant is locked while the winner stalls.
// Latency: combinational grant, lock/last_gnt update on the clock edge.
// Backpressure: i_hold freezes the grant until i_done.
// Ports: clk, rst_n; i_req[1:0] eligible requests; i_hold = granted but not
//        accepted; i_done = granted and accepted; o_gnt[1:0] one-hot grant.
import easyaxi_ar_arb_pkg::*;

module easyaxi_rr_arb (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [MST_NUM-1:0] i_req,
    input  logic               i_hold,
    input  logic               i_done,
    output logic [MST_NUM-1:0] o_gnt
);

    logic r_lock;
    logic r_lock_own;
    logic r_last_gnt;
    logic w_any;
    logic w_own;

    // While locked the request vector is ignored on purpose: the owner
    // may lose eligibility (counter full) but its AR must stay up.
    always_comb begin
        w_any = 1'b0;
        w_own = 1'b0;
        if (r_lock) begin
            w_any = 1'b1;
            w_own = r_lock_own;
        end else if (&i_req) begin
            w_any = 1'b1;
            w_own = ~r_last_gnt;
        end else if (i_req[1]) begin
            w_any = 1'b1;
            w_own = 1'b1;
        end else if (i_req[0]) begin
            w_any = 1'b1;
            w_own = 1'b0;
        end
        o_gnt = w_any ? onehot2(w_own) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock     <= 1'b0;
            r_lock_own <= 1'b0;
            r_last_gnt <= 1'b0;
        end else if (i_done) begin
            r_lock     <= 1'b0;
            r_last_gnt <= w_own;
        end else if (i_hold) begin
            r_lock     <= 1'b1;
            r_lock_own <= w_own;
        end
    end

endmodule

// File: rtl/easyaxi_ar_arb.sv
// Two-master to one-slave EasyAXI read arbiter (AR + R) with outstanding limits.
// Latency: AR and R paths are combinational (zero cycles); counters and ost_err registered.
// Backpressure: a stalled AR grant is locked; R ready follows the RID-selected master.
// Ports: clk/rst_n; m0_ and m1_ AR/R master ports; m_r* shared R payload;
//        s_ AR/R slave port with s_arid = {owner, arid}; ost_err error pulse.
import easyaxi_ar_arb_pkg::*;

module easyaxi_ar_arb #(
    parameter int OST_MAX = 4,
    parameter int CNT_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_arvalid,
    input  logic                    m1_arvalid,
    output logic                    m0_arready,
    output logic                    m1_arready,
    input  logic [`AXI_ID_W-1:0]    m0_arid,
    input  logic [`AXI_ID_W-1:0]    m1_arid,
    input  logic [`AXI_ADDR_W-1:0]  m0_araddr,
    input  logic [`AXI_ADDR_W-1:0]  m1_araddr,
    input  logic [`AXI_LEN_W-1:0]   m0_arlen,
    input  logic [`AXI_LEN_W-1:0]   m1_arlen,
    input  logic [`AXI_SIZE_W-1:0]  m0_arsize,
    input  logic [`AXI_SIZE_W-1:0]  m1_arsize,
    input  logic [`AXI_BURST_W-1:0] m0_arburst,
    input  logic [`AXI_BURST_W-1:0] m1_arburst,
    output logic                    m0_rvalid,
    output logic                    m1_rvalid,
    input  logic                    m0_rready,
    input  logic                    m1_rready,
    output logic [`AXI_ID_W-1:0]    m_rid,
    output logic [`AXI_DATA_W-1:0]  m_rdata,
    output logic [`AXI_RESP_W-1:0]  m_rresp,
    output logic                    m_rlast,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    output logic [`AXI_SID_W-1:0]   s_arid,
    output logic [`AXI_ADDR_W-1:0]  s_araddr,
    output logic [`AXI_LEN_W-1:0]   s_arlen,
    output logic [`AXI_SIZE_W-1:0]  s_arsize,
    output logic [`AXI_BURST_W-1:0] s_arburst,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    input  logic [`AXI_SID_W-1:0]   s_rid,
    input  logic [`AXI_DATA_W-1:0]  s_rdata,
    input  logic [`AXI_RESP_W-1:0]  s_rresp,
    input  logic                    s_rlast,
    output logic                    ost_err
);

    localparam logic [CNT_W-1:0] OST_LIM = CNT_W'(OST_MAX);

    logic [CNT_W-1:0]   r_cnt0;
    logic [CNT_W-1:0]   r_cnt1;
    logic               r_ost_err;

    logic [MST_NUM-1:0] w_elig;
    logic [MST_NUM-1:0] w_gnt;
    logic               w_own;
    ar_pl_t             w_pl0;
    ar_pl_t             w_pl1;
    ar_pl_t             w_pl;
    logic               w_sel;
    logic               w_r_end;
    logic               w_inc0;
    logic               w_inc1;
    logic               w_dec0;
    logic               w_dec1;

    // ---------------- AR path ----------------
    assign w_elig = {m1_arvalid & (r_cnt1 < OST_LIM),
                     m0_arvalid & (r_cnt0 < OST_LIM)};

    // hold/done only feed registers, so s_arready never reaches s_arvalid.
    easyaxi_rr_arb u_rr_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req  (w_elig),
        .i_hold (s_arvalid & ~s_arready),
        .i_done (s_arvalid & s_arready),
        .o_gnt  (w_gnt)
    );

    assign w_own     = w_gnt[1];
    assign s_arvalid = |w_gnt;

    assign w_pl0 = '{id: m0_arid, addr: m0_araddr, len: m0_arlen,
                     size: m0_arsize, burst: m0_arburst};
    assign w_pl1 = '{id: m1_arid, addr: m1_araddr, len: m1_arlen,
                     size: m1_arsize, burst: m1_arburst};
    assign w_pl  = w_own ? w_pl1 : w_pl0;

    assign s_arid    = {w_own, w_pl.id};
    assign s_araddr  = w_pl.addr;
    assign s_arlen   = w_pl.len;
    assign s_arsize  = w_pl.size;
    assign s_arburst = w_pl.burst;

    assign m0_arready = s_arready & s_arvalid & ~w_own;
    assign m1_arready = s_arready & s_arvalid &  w_own;

    // ---------------- R path ----------------
    assign w_sel     = s_rid[`AXI_SID_W-1];
    assign m0_rvalid = s_rvalid & ~w_sel;
    assign m1_rvalid = s_rvalid &  w_sel;
    assign s_rready  = w_sel ? m1_rready : m0_rready;
    assign m_rid     = s_rid[`AXI_ID_W-1:0];
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_rlast   = s_rlast;

    // ---------------- outstanding counters ----------------
    assign w_r_end = s_rvalid & s_rready & s_rlast;
    assign w_inc0  = m0_arvalid & m0_arready;
    assign w_inc1  = m1_arvalid & m1_arready;
    assign w_dec0  = w_r_end & ~w_sel;
    assign w_dec1  = w_r_end &  w_sel;

    // A burst end with nothing outstanding is flagged and the counter
    // saturates at 0; a concurrent AR leaves the count where it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0    <= '0;
            r_cnt1    <= '0;
            r_ost_err <= 1'b0;
        end else begin
            r_ost_err <= (w_dec0 & (r_cnt0 == '0)) | (w_dec1 & (r_cnt1 == '0));
            if (w_inc0 & ~w_dec0)
                r_cnt0 <= r_cnt0 + 1'b1;
            else if (w_dec0 & ~w_inc0 & (r_cnt0 != '0))
                r_cnt0 <= r_cnt0 - 1'b1;
            if (w_inc1 & ~w_dec1)
                r_cnt1 <= r_cnt1 + 1'b1;
            else if (w_dec1 & ~w_inc1 & (r_cnt1 != '0))
                r_cnt1 <= r_cnt1 - 1'b1;
        end
    end

    assign ost_err = r_ost_err;

endmodule
